// File: rtl/error_reporter.sv
// Error-path transmitter: queues CMD/ADD/DATA error pulses and reports each one as a 2-byte UART frame.
// Optional merged-pulse counter on Drop_Cnt is enabled by defining ERR_DROP_CNT_EN.
module error_reporter #(
  parameter logic [7:0] ERR_HDR = 8'hEE,
  parameter int         CNT_W   = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CMDErr,
  input  logic             ADDErr,
  input  logic             DataErr,
  input  logic             TX_Ready,
  output logic [7:0]       TX_Data,
  output logic             TX_Valid,
  output logic [1:0]       Err_type,
  output logic             Err_En,
  output logic             Busy,
  output logic [CNT_W-1:0] Err_Cnt,
  output logic [CNT_W-1:0] Drop_Cnt
);

  // state | meaning
  // IDLE  | nothing in flight, waiting for a pending bit
  // SEL   | pick top-priority pending bit, clear it, strobe Err_En
  // HDR   | offer ERR_HDR byte until accepted
  // CODE  | offer error code byte until accepted
  typedef enum logic [1:0] {IDLE, SEL, HDR, CODE} state_t;

  state_t           state_q, state_nxt;
  logic [2:0]       pend_q, pend_nxt;
  logic [2:0]       pulse, sel_mask, clr;
  logic [1:0]       sel_code, err_type_q;
  logic [CNT_W-1:0] err_cnt_q;

  assign pulse = {DataErr, ADDErr, CMDErr};

  // CMD > ADD > DATA
  always_comb begin
    sel_code = 2'd0;
    sel_mask = 3'b000;
    if (pend_q[0]) begin
      sel_code = 2'd0;
      sel_mask = 3'b001;
    end else if (pend_q[1]) begin
      sel_code = 2'd1;
      sel_mask = 3'b010;
    end else if (pend_q[2]) begin
      sel_code = 2'd2;
      sel_mask = 3'b100;
    end
  end

  assign clr      = (state_q == SEL) ? sel_mask : 3'b000;
  assign pend_nxt = (pend_q & ~clr) | pulse;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      pend_q     <= 3'b000;
      err_type_q <= 2'd0;
      err_cnt_q  <= '0;
    end else begin
      state_q <= state_nxt;
      pend_q  <= pend_nxt;
      if (state_q == SEL) begin
        err_type_q <= sel_code;
        if (err_cnt_q != {CNT_W{1'b1}})
          err_cnt_q <= err_cnt_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE: if (pend_q != 3'b000) state_nxt = SEL;
      SEL:  state_nxt = HDR;
      HDR:  if (TX_Ready) state_nxt = CODE;
      CODE: if (TX_Ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // outputs depend on state only, so TX_Ready never reaches TX_Valid combinationally
  always_comb begin
    TX_Valid = 1'b0;
    TX_Data  = 8'h00;
    Err_En   = 1'b0;
    Err_type = err_type_q;
    Busy     = (state_q != IDLE);
    case (state_q)
      SEL: begin
        Err_En   = 1'b1;
        Err_type = sel_code;
      end
      HDR: begin
        TX_Valid = 1'b1;
        TX_Data  = ERR_HDR;
      end
      CODE: begin
        TX_Valid = 1'b1;
        TX_Data  = {6'b0, err_type_q};
      end
      default: ;
    endcase
  end

  assign Err_Cnt = err_cnt_q;

`ifdef ERR_DROP_CNT_EN
  logic [2:0]       merged;
  logic [CNT_W+1:0] drop_sum;
  logic [CNT_W-1:0] drop_cnt_q;

  // a pulse landing on a bit that SEL clears this cycle starts a fresh report
  assign merged   = pulse & pend_q & ~clr;
  assign drop_sum = {2'b00, drop_cnt_q} + (CNT_W+2)'(merged[0])
                  + (CNT_W+2)'(merged[1]) + (CNT_W+2)'(merged[2]);

  always_ff @(posedge CLK) begin
    if (RST)
      drop_cnt_q <= '0;
    else if (drop_sum > {2'b00, {CNT_W{1'b1}}})
      drop_cnt_q <= {CNT_W{1'b1}};
    else
      drop_cnt_q <= drop_sum[CNT_W-1:0];
  end

  assign Drop_Cnt = drop_cnt_q;
`else
  assign Drop_Cnt = '0;
`endif

endmodule

// File: tb/tb_error_reporter.sv
// Randomized bench for error_reporter against a queue-based frame model; a second
// instance with CNT_W=2 shares stimulus to exercise counter saturation.
module tb_error_reporter;

  logic       CLK = 1'b0;
  logic       RST, CMDErr, ADDErr, DataErr, TX_Ready;
  logic [7:0] TX_Data, s_tx_data;
  logic       TX_Valid, Err_En, Busy, s_tx_valid, s_err_en, s_busy;
  logic [1:0] Err_type, s_err_type;
  logic [7:0] Err_Cnt, Drop_Cnt;
  logic [1:0] s_err_cnt, s_drop_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK = ~CLK;

  error_reporter #(.ERR_HDR(8'hEE), .CNT_W(8)) dut (
    .CLK(CLK), .RST(RST), .CMDErr(CMDErr), .ADDErr(ADDErr), .DataErr(DataErr),
    .TX_Ready(TX_Ready), .TX_Data(TX_Data), .TX_Valid(TX_Valid), .Err_type(Err_type),
    .Err_En(Err_En), .Busy(Busy), .Err_Cnt(Err_Cnt), .Drop_Cnt(Drop_Cnt)
  );

  error_reporter #(.ERR_HDR(8'hEE), .CNT_W(2)) dut_small (
    .CLK(CLK), .RST(RST), .CMDErr(CMDErr), .ADDErr(ADDErr), .DataErr(DataErr),
    .TX_Ready(TX_Ready), .TX_Data(s_tx_data), .TX_Valid(s_tx_valid), .Err_type(s_err_type),
    .Err_En(s_err_en), .Busy(s_busy), .Err_Cnt(s_err_cnt), .Drop_Cnt(s_drop_cnt)
  );

  // model: pending flags per error type, an announce flag and the queue of bytes still to send
  bit         m_pend [3];
  bit         m_ann;
  logic [7:0] m_txq [$];
  int         m_type, m_reports, m_drops;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int top_pending();
    for (int t = 0; t < 3; t++) if (m_pend[t]) return t;
    return 0;
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_clear();
    for (int t = 0; t < 3; t++) m_pend[t] = 0;
    m_ann = 0;
    m_txq.delete();
    m_type = 0;
    m_reports = 0;
    m_drops = 0;
  endtask

  task automatic step(input bit r, input bit c, input bit a, input bit d, input bit rdy);
    bit pl [3];
    int cleared;
    int exp_type;
    RST = r; CMDErr = c; ADDErr = a; DataErr = d; TX_Ready = rdy;
    #1;
    exp_type = m_ann ? top_pending() : m_type;
    chk("tx_valid", TX_Valid, (m_txq.size() != 0) ? 1 : 0);
    chk("tx_data", TX_Data, (m_txq.size() != 0) ? int'(m_txq[0]) : 0);
    chk("err_en", Err_En, m_ann ? 1 : 0);
    chk("err_type", Err_type, exp_type);
    chk("busy", Busy, (m_ann || m_txq.size() != 0) ? 1 : 0);
    chk("err_cnt", Err_Cnt, sat(m_reports, 255));
    chk("err_cnt_small", s_err_cnt, sat(m_reports, 3));
`ifdef ERR_DROP_CNT_EN
    chk("drop_cnt", Drop_Cnt, sat(m_drops, 255));
    chk("drop_cnt_small", s_drop_cnt, sat(m_drops, 3));
`else
    chk("drop_cnt", Drop_Cnt, 0);
    chk("drop_cnt_small", s_drop_cnt, 0);
`endif
    pl[0] = c; pl[1] = a; pl[2] = d;
    if (r) begin
      model_clear();
    end else begin
      cleared = -1;
      if (m_ann) begin
        cleared = top_pending();
        m_type = cleared;
        m_txq.push_back(8'hEE);
        m_txq.push_back(8'(cleared));
        m_reports++;
        m_ann = 0;
      end else if (m_txq.size() != 0) begin
        if (rdy) void'(m_txq.pop_front());
      end else if (m_pend[0] || m_pend[1] || m_pend[2]) begin
        m_ann = 1;
      end
      for (int t = 0; t < 3; t++) begin
        if (pl[t] && m_pend[t] && cleared != t) m_drops++;
        m_pend[t] = (m_pend[t] && cleared != t) || pl[t];
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, rdy);
  endtask

  initial begin
    RST = 1; CMDErr = 0; ADDErr = 0; DataErr = 0; TX_Ready = 1;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    model_clear();
    idle(2, 1);

    // single CMD error, always ready
    step(0, 1, 0, 0, 1);
    idle(7, 1);
    // all three at once: CMD, ADD, DATA frames in order
    step(0, 1, 1, 1, 1);
    idle(16, 1);
    // header held under backpressure for 5 cycles
    step(0, 1, 0, 0, 1);
    idle(2, 1);
    idle(5, 0);
    idle(5, 1);
    // two ADD pulses merged into one report
    step(0, 0, 1, 0, 1);
    step(0, 0, 1, 0, 1);
    idle(7, 1);
    // reset while the code byte is stalled
    step(0, 1, 0, 0, 1);
    idle(3, 1);
    idle(1, 0);
    step(1, 0, 0, 0, 0);
    idle(4, 1);
    // saturation of the small counter
    for (int k = 0; k < 5; k++) begin
      step(0, 0, 0, 1, 1);
      idle(5, 1);
    end

    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 399) == 0),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0));
    end
    idle(10, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
